// File: rtl/la_pkg.sv
// Shared defaults and helpers for the logic-analyser capture path.
// Imported by the run-length encoder and its compare block.
package la_pkg;

   localparam int LA_DATA_W = 8;
   localparam int LA_CNT_W  = 8;

   // All-ones value of a w-bit counter; 64-bit math so w = 32 does not overflow.
   function automatic longint unsigned cnt_max(input int unsigned w);
      return (64'd1 << w) - 64'd1;
   endfunction

endpackage

// File: rtl/la_rle_match.sv
// Masked run compare: decides whether a sample extends the open run.
// Purely combinational so the trigger unit can reuse it unchanged.
module la_rle_match
   import la_pkg::*;
#(
   parameter int DATA_W = LA_DATA_W,
   parameter int CNT_W  = LA_CNT_W
) (
   input  logic [DATA_W-1:0] i_sample,
   input  logic [DATA_W-1:0] i_run_data,
   input  logic [DATA_W-1:0] i_mask,
   input  logic [CNT_W-1:0]  i_run_cnt,
   input  logic              i_rle_en,
   output logic              o_match
);

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

   // A saturated run never matches, so the counter cannot wrap.
   assign o_match = i_rle_en
                    && ((i_sample & i_mask) == (i_run_data & i_mask))
                    && (i_run_cnt != CNT_MAX);

endmodule

// File: rtl/la_rle_encoder.sv
// Run-length encoder between the LA input sampler and the capture SRAM.
// Emits one (data, repeat-count) word per closed run with a 1-cycle write strobe.
module la_rle_encoder
   import la_pkg::*;
#(
   parameter int DATA_W = LA_DATA_W,
   parameter int CNT_W  = LA_CNT_W
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              CLK_EN,
   input  logic              RLE_EN,
   input  logic              FLUSH,
   input  logic [DATA_W-1:0] LA_IN_DATA,
   input  logic [DATA_W-1:0] CH_MASK,
   output logic [DATA_W-1:0] LA_OUT_DATA,
   output logic [CNT_W-1:0]  LA_RLE_OUT_DATA,
   output logic              LA_SRAM_WR,
   output logic              RUN_OPEN
);

   logic [DATA_W-1:0] r_run_data;
   logic [CNT_W-1:0]  r_run_cnt;
   logic              r_run_open;
   logic [DATA_W-1:0] r_out_data;
   logic [CNT_W-1:0]  r_out_cnt;
   logic              r_wr;
   logic              w_match;

   la_rle_match #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
   ) u_match (
      .i_sample   (LA_IN_DATA),
      .i_run_data (r_run_data),
      .i_mask     (CH_MASK),
      .i_run_cnt  (r_run_cnt),
      .i_rle_en   (RLE_EN),
      .o_match    (w_match)
   );

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_run_data <= '0;
         r_run_cnt  <= '0;
         r_run_open <= 1'b0;
         r_out_data <= '0;
         r_out_cnt  <= '0;
         r_wr       <= 1'b0;
      end else begin
         r_wr <= 1'b0;
         if (CLK_EN) begin
            if (!r_run_open) begin
               // FLUSH is consumed here too: the fresh run stays open.
               r_run_data <= LA_IN_DATA;
               r_run_cnt  <= '0;
               r_run_open <= 1'b1;
            end else if (w_match) begin
               if (FLUSH) begin
                  r_out_data <= r_run_data;
                  r_out_cnt  <= r_run_cnt + CNT_W'(1);
                  r_wr       <= 1'b1;
                  r_run_open <= 1'b0;
               end else begin
                  r_run_cnt <= r_run_cnt + CNT_W'(1);
               end
            end else begin
               r_out_data <= r_run_data;
               r_out_cnt  <= r_run_cnt;
               r_wr       <= 1'b1;
               r_run_data <= LA_IN_DATA;
               r_run_cnt  <= '0;
            end
         end else if (FLUSH && r_run_open) begin
            r_out_data <= r_run_data;
            r_out_cnt  <= r_run_cnt;
            r_wr       <= 1'b1;
            r_run_open <= 1'b0;
         end
      end
   end

   assign LA_OUT_DATA     = r_out_data;
   assign LA_RLE_OUT_DATA = r_out_cnt;
   assign LA_SRAM_WR      = r_wr;
   assign RUN_OPEN        = r_run_open;

endmodule
